escalonador_processos: RTL and testbench

Round-robin process scheduler for the multiprogrammed processor. Owns the current process id that drives branch/PC relocation (base = TAM_BLOCO * id), keeps a saved-PC table per process and sequences context switches. Switches happen on yield, halt or quantum expiry. Sits between the control unit and the PC register and stalls the CPU during a switch.

---
 rtl/escalonador_pkg.sv | 33 +++
 rtl/seletor_round_robin.sv | 31 +++
 rtl/escalonador_processos.sv | 195 +++++++++++++++++++
 tb/tb_escalonador_processos.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_pkg.sv
// escalonador_pkg: definitions shared by the process scheduler and by the
// branch-correction logic that relocates branch targets by block base.
//   PC_W        program counter width (absolute instruction address)
//   TAM_BLOCO   default instruction-memory block size per process
//   estado_t    context-switch sequencer states
//   causa_t     latched reason for a context switch
//   base_do_bloco(tam, id)  tam*id computed in 32 bits, truncated to PC_W
package escalonador_pkg;

  localparam int PC_W      = 11;
  localparam int TAM_BLOCO = 300;

  typedef enum logic [1:0] {
    EXECUTANDO = 2'd0,
    SALVA      = 2'd1,
    SELECIONA  = 2'd2,
    CARREGA    = 2'd3
  } estado_t;

  typedef enum logic [1:0] {
    CAUSA_ENCERRAR = 2'd0,
    CAUSA_CEDER    = 2'd1,
    CAUSA_QUANTUM  = 2'd2
  } causa_t;

  function automatic logic [PC_W-1:0] base_do_bloco(input int unsigned tam,
                                                    input int unsigned id);
    logic [31:0] produto;
    produto = tam * id;
    return produto[PC_W-1:0];
  endfunction

endpackage

// File: rtl/seletor_round_robin.sv
// seletor_round_robin: purely combinational round-robin pick of the next
// process. Scans i_atual+1, i_atual+2, ... modulo NUM_PROC and ends at
// i_atual itself, returning the first active slot.
//   i_ativos  active-slot bitmap
//   i_atual   currently running process id
//   o_prox    selected next process id (i_atual when nothing is active)
//   o_valido  at least one active slot was found
module seletor_round_robin #(
  parameter int NUM_PROC = 4,
  parameter int ID_W     = $clog2(NUM_PROC)
) (
  input  logic [NUM_PROC-1:0] i_ativos,
  input  logic [ID_W-1:0]     i_atual,
  output logic [ID_W-1:0]     o_prox,
  output logic                o_valido
);

  // Scanning from the farthest offset down lets the nearest active slot
  // overwrite the result last, so it wins.
  always_comb begin
    o_prox   = i_atual;
    o_valido = 1'b0;
    for (int k = NUM_PROC; k >= 1; k--) begin
      if (i_ativos[(int'(i_atual) + k) % NUM_PROC]) begin
        o_prox   = ID_W'((int'(i_atual) + k) % NUM_PROC);
        o_valido = 1'b1;
      end
    end
  end

endmodule

// File: rtl/escalonador_processos.sv
// escalonador_processos: round-robin process scheduler. Owns the running
// process id (and its block base for PC relocation), a saved-PC table per
// slot, and sequences context switches while stalling the CPU.
//
// Build option: PREEMPCAO_QUANTUM_EN -- when defined, quantum expiry also
// forces a switch; when undefined the quantum counter is not built and
// scheduling is purely cooperative (ceder/encerrar). Ports are identical.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   pc_atual            PC of the next instruction of the running process
//   ciclo_instrucao     one pulse per retired instruction
//   ceder / encerrar    yield / halt, qualified by ciclo_instrucao
//   criar / criar_id    create-process strobe and target slot
//   processo_atual      running process id
//   base_bloco          TAM_BLOCO*processo_atual
//   pc_carga/carrega_pc PC to load and its one-cycle load strobe
//   cpu_parado          CPU stall, high while a switch is in progress
//   processos_ativos    active-slot bitmap (bit 0, the OS, always set)
//
// state      | meaning
// EXECUTANDO | process running, watching for a switch trigger
// SALVA      | store pc_atual for the outgoing process, free slot on halt
// SELECIONA  | latch the round-robin choice of the next process
// CARREGA    | switch id/base, fetch the saved PC, reload the quantum
module escalonador_processos #(
  parameter int NUM_PROC  = 4,
  parameter int TAM_BLOCO = escalonador_pkg::TAM_BLOCO,
  parameter int QUANTUM   = 16,
  parameter int ID_W      = $clog2(NUM_PROC)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [escalonador_pkg::PC_W-1:0] pc_atual,
  input  logic                            ciclo_instrucao,
  input  logic                            ceder,
  input  logic                            encerrar,
  input  logic                            criar,
  input  logic [ID_W-1:0]                 criar_id,
  output logic [ID_W-1:0]                 processo_atual,
  output logic [escalonador_pkg::PC_W-1:0] base_bloco,
  output logic [escalonador_pkg::PC_W-1:0] pc_carga,
  output logic                            carrega_pc,
  output logic                            cpu_parado,
  output logic [NUM_PROC-1:0]             processos_ativos
);

  import escalonador_pkg::*;

  if (QUANTUM < 1 || QUANTUM > 255) begin : g_erro_quantum
    $error("QUANTUM must be within 1..255");
  end
  if (NUM_PROC * TAM_BLOCO > 2048) begin : g_erro_memoria
    $error("NUM_PROC*TAM_BLOCO exceeds the 11-bit instruction space");
  end

  estado_t               r_estado, w_estado_prox;
  causa_t                r_causa, w_causa_nova;
  logic                  w_disparo;
  logic                  w_quantum_expirou;
  logic [ID_W-1:0]       r_processo_atual;
  logic [ID_W-1:0]       r_prox_id;
  logic [PC_W-1:0]       r_base_bloco;
  logic [PC_W-1:0]       r_pc_carga;
  logic                  r_carrega_pc;
  logic                  r_cpu_parado;
  logic [NUM_PROC-1:0]   r_ativos;
  logic [PC_W-1:0]       r_tabela_pc [NUM_PROC];
  logic [ID_W-1:0]       w_prox;
  logic                  w_prox_valido;
  logic                  w_libera;
  logic                  w_aceita_criar;

  seletor_round_robin #(
    .NUM_PROC (NUM_PROC),
    .ID_W     (ID_W)
  ) u_seletor (
    .i_ativos (r_ativos),
    .i_atual  (r_processo_atual),
    .o_prox   (w_prox),
    .o_valido (w_prox_valido)
  );

`ifdef PREEMPCAO_QUANTUM_EN
  localparam logic [7:0] QUANTUM_RECARGA = 8'(QUANTUM - 1);
  logic [7:0] r_quantum;

  // Zero never decrements: a pulse seen at zero is itself the trigger.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_quantum <= QUANTUM_RECARGA;
    end else if (r_estado == CARREGA) begin
      r_quantum <= QUANTUM_RECARGA;
    end else if (r_estado == EXECUTANDO && ciclo_instrucao && !w_disparo) begin
      r_quantum <= r_quantum - 8'd1;
    end
  end

  assign w_quantum_expirou = (r_quantum == 8'd0);
`else
  assign w_quantum_expirou = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= EXECUTANDO;
    else       r_estado <= w_estado_prox;
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_disparo     = 1'b0;
    w_causa_nova  = CAUSA_CEDER;
    unique case (r_estado)
      EXECUTANDO: begin
        if (ciclo_instrucao) begin
          if (encerrar) begin
            w_disparo    = 1'b1;
            w_causa_nova = CAUSA_ENCERRAR;
          end else if (ceder) begin
            w_disparo    = 1'b1;
            w_causa_nova = CAUSA_CEDER;
          end else if (w_quantum_expirou) begin
            w_disparo    = 1'b1;
            w_causa_nova = CAUSA_QUANTUM;
          end
        end
        if (w_disparo) w_estado_prox = SALVA;
      end
      SALVA:     w_estado_prox = SELECIONA;
      SELECIONA: w_estado_prox = CARREGA;
      CARREGA:   w_estado_prox = EXECUTANDO;
      default:   w_estado_prox = EXECUTANDO;
    endcase
  end

  // Halting the OS (slot 0) degrades to a plain yield.
  assign w_libera = (r_estado == SALVA) && (r_causa == CAUSA_ENCERRAR) &&
                    (r_processo_atual != '0);

  // The slot being freed is never inactive yet, but the explicit term keeps
  // "clear wins" independent of that ordering.
  assign w_aceita_criar = criar && (criar_id != '0) &&
                          (32'(criar_id) < NUM_PROC) &&
                          !r_ativos[criar_id] &&
                          !(w_libera && (criar_id == r_processo_atual));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_causa          <= CAUSA_CEDER;
      r_processo_atual <= '0;
      r_prox_id        <= '0;
      r_base_bloco     <= '0;
      r_pc_carga       <= '0;
      r_carrega_pc     <= 1'b0;
      r_cpu_parado     <= 1'b0;
      r_ativos         <= NUM_PROC'(1);
      for (int i = 0; i < NUM_PROC; i++) r_tabela_pc[i] <= '0;
    end else begin
      r_carrega_pc <= (r_estado == CARREGA);
      r_cpu_parado <= (w_estado_prox != EXECUTANDO);

      unique case (r_estado)
        EXECUTANDO: begin
          if (w_disparo) r_causa <= w_causa_nova;
        end
        SALVA: begin
          r_tabela_pc[r_processo_atual] <= pc_atual;
          if (w_libera) r_ativos[r_processo_atual] <= 1'b0;
        end
        SELECIONA: begin
          r_prox_id <= w_prox_valido ? w_prox : r_processo_atual;
        end
        CARREGA: begin
          r_processo_atual <= r_prox_id;
          r_base_bloco     <= base_do_bloco(TAM_BLOCO, 32'(r_prox_id));
          r_pc_carga       <= r_tabela_pc[r_prox_id];
        end
        default: ;
      endcase

      if (w_aceita_criar) begin
        r_ativos[criar_id]    <= 1'b1;
        r_tabela_pc[criar_id] <= base_do_bloco(TAM_BLOCO, 32'(criar_id));
      end
    end
  end

  assign processo_atual   = r_processo_atual;
  assign base_bloco       = r_base_bloco;
  assign pc_carga         = r_pc_carga;
  assign carrega_pc       = r_carrega_pc;
  assign cpu_parado       = r_cpu_parado;
  assign processos_ativos = r_ativos;

endmodule

// File: tb/tb_escalonador_processos.sv
module tb_escalonador_processos;

  localparam int NP    = 4;
  localparam int TAM   = 300;
  localparam int QUANT = 16;
  localparam int ID_W  = $clog2(NP);
`ifdef PREEMPCAO_QUANTUM_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [10:0]     pc_atual = '0;
  logic            ciclo_instrucao = 1'b0;
  logic            ceder = 1'b0;
  logic            encerrar = 1'b0;
  logic            criar = 1'b0;
  logic [ID_W-1:0] criar_id = '0;
  logic [ID_W-1:0] processo_atual;
  logic [10:0]     base_bloco;
  logic [10:0]     pc_carga;
  logic            carrega_pc;
  logic            cpu_parado;
  logic [NP-1:0]   processos_ativos;

  escalonador_processos #(
    .NUM_PROC  (NP),
    .TAM_BLOCO (TAM),
    .QUANTUM   (QUANT),
    .ID_W      (ID_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .pc_atual         (pc_atual),
    .ciclo_instrucao  (ciclo_instrucao),
    .ceder            (ceder),
    .encerrar         (encerrar),
    .criar            (criar),
    .criar_id         (criar_id),
    .processo_atual   (processo_atual),
    .base_bloco       (base_bloco),
    .pc_carga         (pc_carga),
    .carrega_pc       (carrega_pc),
    .cpu_parado       (cpu_parado),
    .processos_ativos (processos_ativos)
  );

  always #5 clock = ~clock;

  int n_testes = 0;
  int n_falhas = 0;

  // Reference model: a switch is a 3-cycle stall counted by m_fase; the
  // round-robin choice is a plain search over an array of active flags.
  int m_fase, m_quant, m_atual, m_prox, m_base, m_pcc;
  bit m_enc, m_car, m_par;
  bit m_ativos [NP];
  int m_tab [NP];

  function automatic void model_reset();
    m_fase = 0; m_enc = 0; m_quant = QUANT - 1;
    m_atual = 0; m_prox = 0; m_base = 0; m_pcc = 0; m_car = 0; m_par = 0;
    for (int i = 0; i < NP; i++) begin
      m_ativos[i] = (i == 0);
      m_tab[i] = 0;
    end
  endfunction

  function automatic int model_ativos_vec();
    int v = 0;
    for (int i = 0; i < NP; i++) if (m_ativos[i]) v += (1 << i);
    return v;
  endfunction

  function automatic void model_step(bit ci, bit cd, bit en, bit cr, int id, int pc);
    bit aceita;
    bit novo_car;
    aceita = cr && id != 0 && id < NP && !m_ativos[id];
    novo_car = (m_fase == 3);
    case (m_fase)
      0: if (ci) begin
           if (en) begin m_fase = 1; m_enc = 1; end
           else if (cd) begin m_fase = 1; m_enc = 0; end
           else if (PREEMPT && m_quant == 0) begin m_fase = 1; m_enc = 0; end
           else if (m_quant > 0) m_quant--;
         end
      1: begin
           m_tab[m_atual] = pc;
           if (m_enc && m_atual != 0) m_ativos[m_atual] = 0;
           m_fase = 2;
         end
      2: begin
           m_prox = m_atual;
           for (int k = NP; k >= 1; k--)
             if (m_ativos[(m_atual + k) % NP]) m_prox = (m_atual + k) % NP;
           m_fase = 3;
         end
      default: begin
           m_atual = m_prox;
           m_base = (TAM * m_prox) % 2048;
           m_pcc = m_tab[m_prox];
           m_quant = QUANT - 1;
           m_fase = 0;
         end
    endcase
    if (aceita) begin
      m_ativos[id] = 1;
      m_tab[id] = (TAM * id) % 2048;
    end
    m_car = novo_car;
    m_par = (m_fase != 0);
  endfunction

  task automatic conferir(input string nome, input int atual, input int base,
                          input int pcc, input bit car, input bit par, input int ativos);
    logic [ID_W+11+11+2+NP-1:0] obt, esp;
    obt = {processo_atual, base_bloco, pc_carga, carrega_pc, cpu_parado, processos_ativos};
    esp = {ID_W'(atual), 11'(base), 11'(pcc), car, par, NP'(ativos)};
    n_testes++;
    if (obt !== esp) begin
      n_falhas++;
      $display("FAIL %s: got atual=%0d base=%0d pc_carga=%0d carrega_pc=%b cpu_parado=%b ativos=%b | expected atual=%0d base=%0d pc_carga=%0d carrega_pc=%b cpu_parado=%b ativos=%b",
               nome, processo_atual, base_bloco, pc_carga, carrega_pc, cpu_parado,
               processos_ativos, atual, base, pcc, car, par, NP'(ativos));
    end
  endtask

  task automatic passo(input bit ci, input bit cd, input bit en, input bit cr,
                       input int id, input int pc);
    @(negedge clock);
    ciclo_instrucao = ci; ceder = cd; encerrar = en; criar = cr;
    criar_id = ID_W'(id); pc_atual = 11'(pc);
    @(posedge clock);
    model_step(ci, cd, en, cr, id, pc);
    #1;
  endtask

  task automatic aplicar_reset();
    @(negedge clock);
    reset = 1'b1;
    ciclo_instrucao = 0; ceder = 0; encerrar = 0; criar = 0; criar_id = '0; pc_atual = '0;
    @(posedge clock);
    #1;
    model_reset();
    conferir("reset", 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    bit ci, cd, en, cr;
    int id, pc;
    int e_atual, e_base, e_pcc;
    bit e_car, e_par;
    int e_ativos;
  } vetor_t;

  vetor_t tabela [$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int paradas;
    int pc_hold;
    bit ci, cd, en, cr;
    int id;

    //              ci cd en cr id pc    atual base pcc car par ativos
    tabela.push_back('{0,0,0,1,2,0,     0,  0,  0,  0,0, 5});
    tabela.push_back('{1,1,0,0,0,37,    0,  0,  0,  0,1, 5});
    tabela.push_back('{0,0,0,0,0,37,    0,  0,  0,  0,1, 5});
    tabela.push_back('{0,0,0,0,0,37,    0,  0,  0,  0,1, 5});
    tabela.push_back('{0,0,0,0,0,37,    2,600,600,  1,0, 5});
    tabela.push_back('{1,0,0,0,0,600,   2,600,600,  0,0, 5});
    tabela.push_back('{0,1,0,0,0,600,   2,600,600,  0,0, 5});
    tabela.push_back('{0,0,0,1,0,600,   2,600,600,  0,0, 5});
    tabela.push_back('{0,0,0,1,1,600,   2,600,600,  0,0, 7});
    tabela.push_back('{0,0,0,1,3,600,   2,600,600,  0,0,15});
    tabela.push_back('{0,0,0,1,2,600,   2,600,600,  0,0,15});
    tabela.push_back('{1,0,1,0,0,650,   2,600,600,  0,1,15});
    tabela.push_back('{0,0,0,0,0,650,   2,600,600,  0,1,11});
    tabela.push_back('{0,0,0,0,0,650,   2,600,600,  0,1,11});
    tabela.push_back('{0,0,0,0,0,650,   3,900,900,  1,0,11});
    tabela.push_back('{0,0,0,0,0,900,   3,900,900,  0,0,11});
    tabela.push_back('{1,1,0,0,0,905,   3,900,900,  0,1,11});
    tabela.push_back('{0,0,0,0,0,905,   3,900,900,  0,1,11});
    tabela.push_back('{0,0,0,0,0,905,   3,900,900,  0,1,11});
    tabela.push_back('{0,0,0,0,0,905,   0,  0, 37,  1,0,11});
    tabela.push_back('{0,0,0,0,0,37,    0,  0, 37,  0,0,11});
    tabela.push_back('{1,1,0,0,0,40,    0,  0, 37,  0,1,11});
    tabela.push_back('{0,0,0,0,0,40,    0,  0, 37,  0,1,11});
    tabela.push_back('{0,0,0,0,0,40,    0,  0, 37,  0,1,11});
    tabela.push_back('{0,0,0,0,0,40,    1,300,300,  1,0,11});
    tabela.push_back('{0,0,0,0,0,300,   1,300,300,  0,0,11});
    tabela.push_back('{1,0,1,0,0,310,   1,300,300,  0,1,11});
    tabela.push_back('{0,0,0,0,0,310,   1,300,300,  0,1, 9});
    tabela.push_back('{0,0,0,0,0,310,   1,300,300,  0,1, 9});
    tabela.push_back('{0,0,0,0,0,310,   3,900,905,  1,0, 9});
    tabela.push_back('{0,0,0,1,1,905,   3,900,905,  0,0,11});
    tabela.push_back('{1,1,0,0,0,910,   3,900,905,  0,1,11});
    tabela.push_back('{0,0,0,0,0,910,   3,900,905,  0,1,11});
    tabela.push_back('{0,0,0,0,0,910,   3,900,905,  0,1,11});
    tabela.push_back('{0,0,0,0,0,910,   0,  0, 40,  1,0,11});
    tabela.push_back('{1,1,0,0,0,41,    0,  0, 40,  0,1,11});
    tabela.push_back('{0,0,0,0,0,41,    0,  0, 40,  0,1,11});
    tabela.push_back('{0,0,0,0,0,41,    0,  0, 40,  0,1,11});
    tabela.push_back('{0,0,0,0,0,41,    1,300,300,  1,0,11});
    tabela.push_back('{0,0,0,0,0,300,   1,300,300,  0,0,11});

    aplicar_reset();
    for (int i = 0; i < tabela.size(); i++) begin
      passo(tabela[i].ci, tabela[i].cd, tabela[i].en, tabela[i].cr,
            tabela[i].id, tabela[i].pc);
      conferir($sformatf("vetor_%0d", i), tabela[i].e_atual, tabela[i].e_base,
               tabela[i].e_pcc, tabela[i].e_car, tabela[i].e_par, tabela[i].e_ativos);
    end

    // Quantum expiry with only the OS active, or no switch at all when
    // scheduling is cooperative.
    aplicar_reset();
    if (PREEMPT) begin
      for (int p = 1; p <= QUANT; p++) begin
        passo(1, 0, 0, 0, 0, 123);
        conferir($sformatf("quantum_pulso_%0d", p), 0, 0, 0, 0, (p == QUANT), 1);
      end
      passo(0, 0, 0, 0, 0, 123);
      conferir("quantum_parado_2", 0, 0, 0, 0, 1, 1);
      passo(0, 0, 0, 0, 0, 123);
      conferir("quantum_parado_3", 0, 0, 0, 0, 1, 1);
      passo(0, 0, 0, 0, 0, 123);
      conferir("quantum_carga", 0, 0, 123, 1, 0, 1);
      for (int p = 0; p < 4; p++) begin
        passo(1, 0, 0, 0, 0, 123);
        conferir("quantum_apos", 0, 0, 123, 0, 0, 1);
      end
    end else begin
      paradas = 0;
      for (int p = 0; p < 100; p++) begin
        passo(1, 0, 0, 0, 0, 7);
        if (cpu_parado !== 1'b0) paradas++;
      end
      n_testes++;
      if (paradas != 0) begin
        n_falhas++;
        $display("FAIL coop_sem_troca: got %0d stalled cycles, expected 0", paradas);
      end
      conferir("coop_final", 0, 0, 0, 0, 0, 1);
    end

    // Halt coinciding with quantum expiry, then reset inside SELECIONA.
    aplicar_reset();
    passo(0, 0, 0, 1, 1, 5);
    conferir("p5_criar", 0, 0, 0, 0, 0, 3);
    passo(1, 1, 0, 0, 0, 5);
    passo(0, 0, 0, 0, 0, 5);
    passo(0, 0, 0, 0, 0, 5);
    passo(0, 0, 0, 0, 0, 5);
    conferir("p5_em_1", 1, 300, 300, 1, 0, 3);
    for (int p = 0; p < QUANT - 1; p++) passo(1, 0, 0, 0, 0, 320);
    conferir("p5_antes", 1, 300, 300, 0, 0, 3);
    passo(1, 0, 1, 0, 0, 330);
    conferir("p5_disparo", 1, 300, 300, 0, 1, 3);
    passo(0, 0, 0, 0, 0, 330);
    conferir("p5_libera", 1, 300, 300, 0, 1, 1);
    passo(0, 0, 0, 0, 0, 330);
    conferir("p5_seleciona", 1, 300, 300, 0, 1, 1);
    passo(0, 0, 0, 0, 0, 330);
    conferir("p5_carga", 0, 0, 5, 1, 0, 1);
    passo(0, 0, 0, 0, 0, 5);
    conferir("p5_unica_troca", 0, 0, 5, 0, 0, 1);
    passo(0, 0, 0, 1, 2, 5);
    passo(1, 1, 0, 0, 0, 9);
    passo(0, 0, 0, 0, 0, 9);
    conferir("p5_em_selecao", 0, 0, 5, 0, 1, 5);
    #2;
    reset = 1'b1;
    #1;
    conferir("p5_reset_assincrono", 0, 0, 0, 0, 0, 1);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      passo(0, 0, 0, 0, 0, 9);
      conferir("p5_troca_abortada", 0, 0, 0, 0, 0, 1);
    end

    // Randomized traffic against the reference model.
    aplicar_reset();
    pc_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_par) begin
        ci = 0;
      end else begin
        ci = ($urandom_range(0, 1) == 1);
        pc_hold = $urandom_range(0, 2047);
      end
      cd = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 19) == 0);
      cr = ($urandom_range(0, 7) == 0);
      id = $urandom_range(0, NP - 1);
      passo(ci, cd, en, cr, id, pc_hold);
      conferir("aleatorio", m_atual, m_base, m_pcc, m_car, m_par, model_ativos_vec());
    end

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
